// File: rtl/ex_flag_commit.sv
// ex_flag_commit: execute-stage flag owner and commit register.
// Holds the architectural Carry and Zero flags. Evaluates the conditional
// execution predicate for the instruction in EX, and registers the committed
// result and write-enable for the MEM stage. Z is also updated late by loads
// that complete in MEM.
// Optional feature: define FLAG_STATS_EN to build saturating counters of
// executed and squashed instructions. Without it, exec_cnt and squash_cnt
// read as zero.
module ex_flag_commit #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_flush,
  input  logic [1:0]       ex_class,
  input  logic [1:0]       ex_cond,
  input  logic [DW:0]      alu_result,
  input  logic             alu_z,
  input  logic             mem_lw_valid,
  input  logic             mem_lw_zero,
  output logic             c_flag,
  output logic             z_flag,
  output logic             wb_en_q,
  output logic [DW-1:0]    wb_data_q,
  output logic             squash_q,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam logic [1:0] CLS_ADD  = 2'b01;  // writes C and Z
  localparam logic [1:0] CLS_NAND = 2'b10;  // writes Z only
  localparam logic [1:0] CND_C    = 2'b01;
  localparam logic [1:0] CND_Z    = 2'b10;

  logic c_eff;
  logic z_eff;
  logic pass;
  logic live;
  logic do_exec;
  logic do_squash;
  logic wr_c;
  logic wr_z;

  // Evaluate the predicate against flags forwarded from an older load in MEM.
  always_comb begin
    // NOTE: every signal driven here gets a value first, so no path can infer a latch.
    c_eff = c_flag;
    z_eff = mem_lw_valid ? mem_lw_zero : z_flag;
    unique case (ex_cond)
      CND_C:   pass = c_eff;
      CND_Z:   pass = z_eff;
      default: pass = 1'b1;  // 00 and 11 mean "always"
    endcase
    live      = ex_valid & ~ex_flush & ~ex_stall;
    do_exec   = live & pass;
    do_squash = live & ~pass;
    wr_c      = do_exec & (ex_class == CLS_ADD);
    wr_z      = do_exec & ((ex_class == CLS_ADD) | (ex_class == CLS_NAND));
  end

  // Commit register: updated only when EX is not stalled.
  // A flushed or empty slot commits nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      squash_q  <= 1'b0;
      wb_data_q <= '0;
    end else if (!ex_stall) begin
      wb_en_q  <= do_exec;
      squash_q <= do_squash;
      if (do_exec) wb_data_q <= alu_result[DW-1:0];
    end
  end

  // Carry is a raw copy of the ALU carry/borrow bit and is never inverted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    c_flag <= 1'b0;
    else if (wr_c) c_flag <= alu_result[DW];
  end

  // Zero flag. When both update on the same edge, the younger EX instruction
  // takes priority over the late load update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            z_flag <= 1'b0;
    else if (wr_z)         z_flag <= alu_z;
    else if (mem_lw_valid) z_flag <= mem_lw_zero;
  end

`ifdef FLAG_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating statistics counters for executed and squashed instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else begin
      if (do_exec && exec_cnt != CNT_MAX)     exec_cnt   <= exec_cnt + 1'b1;
      if (do_squash && squash_cnt != CNT_MAX) squash_cnt <= squash_cnt + 1'b1;
    end
  end
`else
  assign exec_cnt   = '0;
  assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_flag_commit.sv
// tb_ex_flag_commit: the directed test-plan scenarios, followed by
// randomized traffic. Each result is compared with a behavioural model of
// the flag and commit rules.
module tb_ex_flag_commit;

  localparam int DW    = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid, ex_stall, ex_flush;
  logic [1:0]       ex_class, ex_cond;
  logic [DW:0]      alu_result;
  logic             alu_z;
  logic             mem_lw_valid, mem_lw_zero;
  logic             c_flag, z_flag, wb_en_q, squash_q;
  logic [DW-1:0]    wb_data_q;
  logic [CNT_W-1:0] exec_cnt, squash_cnt;

  ex_flag_commit #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .ex_class(ex_class), .ex_cond(ex_cond),
    .alu_result(alu_result), .alu_z(alu_z),
    .mem_lw_valid(mem_lw_valid), .mem_lw_zero(mem_lw_zero),
    .c_flag(c_flag), .z_flag(z_flag),
    .wb_en_q(wb_en_q), .wb_data_q(wb_data_q), .squash_q(squash_q),
    .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  bit        m_c, m_z, m_wb_en, m_sq;
  bit [15:0] m_data;
  int        m_exec, m_sqc;

  task automatic model_reset();
    m_c = 0; m_z = 0; m_wb_en = 0; m_sq = 0; m_data = 0; m_exec = 0; m_sqc = 0;
  endtask

  // Apply one clock edge of the specification's rules using the current inputs.
  task automatic model_step();
    bit zf, ok, ex_ok;
    zf = mem_lw_valid ? mem_lw_zero : m_z;
    case (ex_cond)
      2'b01:   ok = m_c;
      2'b10:   ok = zf;
      default: ok = 1;
    endcase
    ex_ok = 0;
    if (mem_lw_valid) m_z = mem_lw_zero;
    if (!ex_stall) begin
      if (ex_valid && !ex_flush) begin
        m_wb_en = ok;
        m_sq    = !ok;
        if (ok) begin
          ex_ok  = 1;
          m_data = alu_result[15:0];
          if (m_exec < 65535) m_exec++;
        end else if (m_sqc < 65535) m_sqc++;
      end else begin
        m_wb_en = 0;
        m_sq    = 0;
      end
    end
    if (ex_ok && ex_class == 2'b01) begin m_c = alu_result[16]; m_z = alu_z; end
    if (ex_ok && ex_class == 2'b10) m_z = alu_z;
  endtask

  task automatic compare_all(input string tag);
    int e_exec, e_sqc;
`ifdef FLAG_STATS_EN
    e_exec = m_exec; e_sqc = m_sqc;
`else
    e_exec = 0; e_sqc = 0;
`endif
    check({tag, ".c"},      32'(c_flag),     32'(m_c));
    check({tag, ".z"},      32'(z_flag),     32'(m_z));
    check({tag, ".wb_en"},  32'(wb_en_q),    32'(m_wb_en));
    check({tag, ".data"},   32'(wb_data_q),  32'(m_data));
    check({tag, ".squash"}, 32'(squash_q),   32'(m_sq));
    check({tag, ".exec"},   32'(exec_cnt),   32'(e_exec));
    check({tag, ".sqcnt"},  32'(squash_cnt), 32'(e_sqc));
  endtask

  task automatic drive(input bit v, input bit s, input bit f, input bit [1:0] cls,
                       input bit [1:0] cnd, input bit [16:0] res, input bit z,
                       input bit lv, input bit lz);
    ex_valid = v; ex_stall = s; ex_flush = f; ex_class = cls; ex_cond = cnd;
    alu_result = res; alu_z = z; mem_lw_valid = lv; mem_lw_zero = lz;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Add-type, always: carry out and zero result.
    drive(1, 0, 0, 2'b01, 2'b00, 17'h1_0000, 1, 0, 0);
    tick("add_c1z1");
    check("add_c1z1.c_const", 32'(c_flag), 1);
    check("add_c1z1.wben_const", 32'(wb_en_q), 1);

    // Clear C and Z, then a carry-predicated add fails.
    drive(1, 0, 0, 2'b01, 2'b00, 17'h0_0001, 0, 0, 0);
    tick("add_c0z0");
    drive(1, 0, 0, 2'b01, 2'b01, 17'h0_0005, 0, 0, 0);
    tick("adc_fail");
    check("adc_fail.squash_const", 32'(squash_q), 1);
    check("adc_fail.c_const", 32'(c_flag), 0);

    // Load forwarding enables a Z-predicated nand; the EX Z write wins.
    drive(1, 0, 0, 2'b10, 2'b10, 17'h0_00FF, 0, 1, 1);
    tick("ndz_fwd");
    check("ndz_fwd.data_const", 32'(wb_data_q), 32'h00FF);
    check("ndz_fwd.z_const", 32'(z_flag), 0);

    // Stall for three cycles with a pending add, then commit once.
    drive(1, 1, 0, 2'b01, 2'b00, 17'h1_1234, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall.data_frozen", 32'(wb_data_q), 32'h00FF);
    check("stall.c_frozen", 32'(c_flag), 0);
    drive(1, 0, 0, 2'b01, 2'b00, 17'h1_1234, 0, 0, 0);
    tick("stall_release");
    check("stall_release.data_const", 32'(wb_data_q), 32'h1234);
    drive(0, 0, 0, 2'b01, 2'b00, 17'h1_1234, 0, 0, 0);
    tick("after_commit");
    check("after_commit.wben_const", 32'(wb_en_q), 0);

    // Flush beats a passing add.
    drive(1, 0, 1, 2'b01, 2'b00, 17'h1_FFFF, 1, 0, 0);
    tick("flush");
    check("flush.z_const", 32'(z_flag), 0);

    // Asynchronous reset in mid-cycle, while wb_en_q=1 and C=1.
    drive(1, 0, 0, 2'b01, 2'b00, 17'h1_0001, 0, 0, 0);
    tick("pre_reset");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [16:0] r;
      r = 17'($urandom);
      if ($urandom_range(0, 7) == 0) r[15:0] = '0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, 2'($urandom), 2'($urandom), r,
            r[15:0] == 16'h0, $urandom_range(0, 3) == 0, 1'($urandom));
      tick("rand");
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_flag_commit.md
Name: ex_flag_commit

Overview:
- Execute-stage companion to the 16-bit ALU; consumes the ALU's 17-bit result and zero flag.
- Owns the architectural Carry (C) and Zero (Z) flag registers.
- Evaluates conditional execution (ADC/ADZ/NDC/NDZ-style predicates) and registers the committed result and write-enable toward the MEM stage.
- Applies late Z updates from loads completing in MEM.

Parameters:
- DW, 16, data width; the ALU result input is DW+1 bits wide.
- CNT_W, 16, width of the statistics counters (used only with FLAG_STATS_EN).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  a valid instruction is in EX
- ex_stall  in  1  EX hold: no EX state change, outputs hold
- ex_flush  in  1  kill the instruction currently in EX
- ex_class  in  2  flag effect: 00 none, 01 writes C and Z (add-type), 10 writes Z only (nand-type), 11 none
- ex_cond  in  2  predicate: 00 always, 01 execute if C=1, 10 execute if Z=1, 11 always
- alu_result  in  DW+1  ALU output; bit DW is the carry
- alu_z  in  1  ALU zero flag for alu_result[DW-1:0]
- mem_lw_valid  in  1  single-cycle pulse: a load completes in MEM
- mem_lw_zero  in  1  loaded value is zero (qualified by mem_lw_valid)
- c_flag  out  1  architectural carry
- z_flag  out  1  architectural zero
- wb_en_q  out  1  registered result write-enable for the next stage
- wb_data_q  out  DW  registered committed result
- squash_q  out  1  registered pulse: the EX instruction failed its predicate
- exec_cnt  out  CNT_W  executed-instruction counter
- squash_cnt  out  CNT_W  squashed-instruction counter

Behaviour:
- Reset (asynchronous, rst_n=0): c_flag, z_flag, wb_en_q, squash_q, wb_data_q and both counters go to 0 immediately. Release is synchronous to clk.
- Forwarded flags:
  - c_eff = c_flag.
  - z_eff = mem_lw_zero when mem_lw_valid=1, otherwise z_flag. The load in MEM is older than the EX instruction.
- Predicate: pass = (ex_cond==00) | (ex_cond==11) | (ex_cond==01 & c_eff) | (ex_cond==10 & z_eff).
- live = ex_valid & ~ex_flush & ~ex_stall.
- Each rising edge, when live:
  - pass=1: wb_en_q<=1, wb_data_q<=alu_result[DW-1:0], squash_q<=0.
    - class 01: c_flag<=alu_result[DW], z_flag<=alu_z.
    - class 10: z_flag<=alu_z; C is unchanged.
  - pass=0: wb_en_q<=0, squash_q<=1, flags unchanged, wb_data_q holds.
- ex_flush=1 with ~ex_stall: wb_en_q<=0, squash_q<=0, no flag change; flush beats pass.
- ex_valid=0 with ~ex_stall: wb_en_q<=0, squash_q<=0.
- ex_stall=1: wb_en_q, wb_data_q, squash_q and EX-driven flag updates all hold. Flush during a stall is ignored.
- Load Z update: mem_lw_valid=1 sets z_flag<=mem_lw_zero at the edge regardless of stall.
  - Same edge as a live class-01/10 pass: the EX update wins for Z (the EX instruction is younger).
- Latency: 1 cycle from EX inputs to wb_en_q/wb_data_q/flags.
- Carry is a plain copy of bit DW. For subtraction it is the raw borrow bit, with no inversion.
- Reset asserted mid-operation clears the pending commit; there is no replay.

Optional Feature:
- Macro FLAG_STATS_EN.
- Defined:
  - exec_cnt increments on every live pass.
  - squash_cnt increments on every live predicate fail.
  - Both saturate at 2^CNT_W-1 and reset to 0.
- Undefined: no counter registers; exec_cnt and squash_cnt are tied to 0. Ports always exist.

Test Plan:
- Reset then add-type, cond 00, alu_result=17'h1_0000, alu_z=1 -> next edge c_flag=1, z_flag=1, wb_en_q=1, wb_data_q=0.
- With C=0: cond 01, class 01, alu_result=17'h0_0005 -> wb_en_q=0, squash_q=1, C=0 and Z unchanged; with FLAG_STATS_EN, squash_cnt=1.
- Z=0, mem_lw_valid=1, mem_lw_zero=1, same-cycle EX cond 10, class 10, alu_z=0, result 16'h00FF -> executes: wb_en_q=1, wb_data_q=16'h00FF, z_flag=0 (EX wins).
- ex_stall=1 for 3 cycles with a pending add-type -> outputs and flags frozen; then ex_stall=0 -> commit on the first free edge, wb_en_q=1 for exactly one cycle.
- ex_flush=1 with a passing add-type, alu_result=17'h1_FFFF -> wb_en_q=0, C and Z unchanged, squash_q=0.
- rst_n pulsed low mid-cycle while wb_en_q=1, C=1 -> all outputs 0 immediately, before the next clk edge.
